// File: rtl/ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : ff_bank
// Purpose  : Bank of WIDTH run-time configurable flip-flops (D / T / SR / JK,
//            selected by a shared mode input) with update enable,
//            programmable reset value, and sticky per-bit / counted detection
//            of SR invalid (S=R=1) input combinations.
// Ports    : clk        rising-edge clock
//            rst        asynchronous active-high reset
//            i_en       update enable (low: q, err, err_cnt hold)
//            i_mode     00 D, 01 T, 10 SR, 11 JK
//            i_a        per-bit D / T / S / J
//            i_b        per-bit R / K (ignored in D and T modes)
//            i_clr_err  synchronous clear of o_err and o_err_cnt
//            o_q        stored state
//            o_qn       inverse of o_q
//            o_err      sticky per-bit SR invalid flag
//            o_err_cnt  saturating count of cycles with any SR invalid bit
// Revision : 1.0 - initial release
// ============================================================================
module ff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qn,
    output logic [WIDTH-1:0] o_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [1:0]       c_MODE_D  = 2'b00;
    localparam logic [1:0]       c_MODE_T  = 2'b01;
    localparam logic [1:0]       c_MODE_SR = 2'b10;
    localparam logic [1:0]       c_MODE_JK = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_inv;
    logic             w_any_inv;

    // Per-bit next-state and invalid-event decode.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                w_q_nxt[gi] = r_q[gi];
                unique case (i_mode)
                    c_MODE_D:  w_q_nxt[gi] = i_a[gi];
                    c_MODE_T:  w_q_nxt[gi] = r_q[gi] ^ i_a[gi];
                    // S=R=1 is invalid: the bit holds.
                    c_MODE_SR: w_q_nxt[gi] = (i_a[gi] ^ i_b[gi]) ? i_a[gi] : r_q[gi];
                    c_MODE_JK: w_q_nxt[gi] = (i_a[gi] & i_b[gi]) ? ~r_q[gi] :
                                             (i_a[gi] | i_b[gi]) ? i_a[gi]  : r_q[gi];
                    default:   w_q_nxt[gi] = r_q[gi];
                endcase
            end

            // Gated by en so that a disabled cycle never raises an event.
            assign w_inv[gi] = i_en & (i_mode == c_MODE_SR) & i_a[gi] & i_b[gi];
        end
    endgenerate

    assign w_any_inv = |w_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= w_q_nxt;
        end
    end

    // Error tracking does not look at i_en directly: w_inv is already zero
    // when disabled, and the clear must still act in that case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err     <= '0;
            r_err_cnt <= '0;
        end else if (i_clr_err) begin
            // An event in the clearing cycle survives the clear.
            r_err     <= w_inv;
            r_err_cnt <= w_any_inv ? c_CNT_ONE : '0;
        end else begin
            r_err <= r_err | w_inv;
            if (w_any_inv && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_q       = r_q;
    assign o_qn      = ~r_q;
    assign o_err     = r_err;
    assign o_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_bank
// Purpose  : Directed self-checking bench for ff_bank (WIDTH=8,
//            RESET_VAL=8'hA5, CNT_W=2 so counter saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_bank;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = 2;
    localparam logic [7:0] RV    = 8'hA5;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] err;
    logic [CNT_W-1:0] err_cnt;

    int checks;
    int errors;

    ff_bank #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RV),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_en      (en),
        .i_mode    (mode),
        .i_a       (a),
        .i_b       (b),
        .i_clr_err (clr_err),
        .o_q       (q),
        .o_qn      (qn),
        .o_err     (err),
        .o_err_cnt (err_cnt)
    );

    // One full clock period; outputs are sampled 5 units after the rising edge.
    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic test_reset();
        clk = 1'b0; en = 1'b0; mode = 2'b10; a = 8'hFF; b = 8'hFF; clr_err = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want a5", q); end
        checks++;
        if (qn !== 8'h5A) begin errors++; $display("FAIL reset_qn: got %h want 5a", qn); end
        checks++;
        if (err !== 8'h00 || err_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_err: got err=%h cnt=%0d want 00/0", err, err_cnt);
        end
        #2 rst = 1'b0;
        // en=0 with an SR invalid input present: nothing may change.
        repeat (3) tick();
        checks++;
        if (q !== 8'hA5 || err !== 8'h00 || err_cnt !== 2'd0) begin
            errors++; $display("FAIL en_low_hold: got q=%h err=%h cnt=%0d want a5/00/0", q, err, err_cnt);
        end
    endtask

    task automatic test_d_t();
        en = 1'b1; mode = 2'b00; a = 8'h3C; b = 8'h00;
        tick();
        checks++;
        if (q !== 8'h3C || qn !== 8'hC3) begin
            errors++; $display("FAIL d_mode: got q=%h qn=%h want 3c/c3", q, qn);
        end
        mode = 2'b01; a = 8'h0F;
        tick();
        checks++;
        if (q !== 8'h33) begin errors++; $display("FAIL t_mode_1: got %h want 33", q); end
        tick();
        checks++;
        if (q !== 8'h3C) begin errors++; $display("FAIL t_mode_2: got %h want 3c", q); end
    endtask

    task automatic test_sr();
        mode = 2'b00; a = 8'h00; b = 8'h00;
        tick();
        mode = 2'b10; a = 8'hF0; b = 8'h00;
        tick();
        checks++;
        if (q !== 8'hF0) begin errors++; $display("FAIL sr_set: got %h want f0", q); end
        a = 8'h00; b = 8'h30;
        tick();
        checks++;
        if (q !== 8'hC0) begin errors++; $display("FAIL sr_reset: got %h want c0", q); end
        a = 8'h03; b = 8'h03;
        tick();
        checks++;
        if (q !== 8'hC0 || err !== 8'h03 || err_cnt !== 2'd1) begin
            errors++; $display("FAIL sr_invalid: got q=%h err=%h cnt=%0d want c0/03/1", q, err, err_cnt);
        end
        repeat (2) tick();
        checks++;
        if (err_cnt !== 2'd3 || err !== 8'h03) begin
            errors++; $display("FAIL sr_invalid_cnt: got err=%h cnt=%0d want 03/3", err, err_cnt);
        end
    endtask

    task automatic test_jk();
        mode = 2'b00; a = 8'hAA; b = 8'h00;
        tick();
        mode = 2'b11; a = 8'hFF; b = 8'hFF;
        tick();
        checks++;
        if (q !== 8'h55) begin errors++; $display("FAIL jk_toggle_1: got %h want 55", q); end
        tick();
        checks++;
        if (q !== 8'hAA) begin errors++; $display("FAIL jk_toggle_2: got %h want aa", q); end
        a = 8'h0F; b = 8'hF0;
        tick();
        checks++;
        if (q !== 8'h0F || err_cnt !== 2'd3 || err !== 8'h03) begin
            errors++; $display("FAIL jk_set_reset: got q=%h err=%h cnt=%0d want 0f/03/3", q, err, err_cnt);
        end
    endtask

    task automatic test_clear_sat();
        // Start from a clean counter.
        mode = 2'b00; a = 8'h00; b = 8'h00; clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++;
        if (err !== 8'h00 || err_cnt !== 2'd0) begin
            errors++; $display("FAIL clr_plain: got err=%h cnt=%0d want 00/0", err, err_cnt);
        end
        mode = 2'b10; a = 8'h03; b = 8'h03;
        repeat (2) tick();
        checks++;
        if (err_cnt !== 2'd2) begin errors++; $display("FAIL cnt_count: got %0d want 2", err_cnt); end
        repeat (3) tick();
        checks++;
        if (err_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d want 3", err_cnt); end
        // Clear with a different invalid pattern present: err takes only the new one.
        a = 8'h0C; b = 8'h0C; clr_err = 1'b1;
        tick();
        checks++;
        if (err !== 8'h0C || err_cnt !== 2'd1) begin
            errors++; $display("FAIL clr_with_inv: got err=%h cnt=%0d want 0c/1", err, err_cnt);
        end
        a = 8'h00; b = 8'h00;
        tick();
        checks++;
        if (err !== 8'h00 || err_cnt !== 2'd0) begin
            errors++; $display("FAIL clr_no_inv: got err=%h cnt=%0d want 00/0", err, err_cnt);
        end
        // Clear still acts while disabled.
        clr_err = 1'b0; a = 8'h80; b = 8'h80;
        tick();
        en = 1'b0; clr_err = 1'b1;
        tick();
        checks++;
        if (err !== 8'h00 || err_cnt !== 2'd0 || q !== 8'h00) begin
            errors++; $display("FAIL clr_en_low: got q=%h err=%h cnt=%0d want 00/00/0", q, err, err_cnt);
        end
        en = 1'b1; clr_err = 1'b0;
    endtask

    task automatic test_async_mid();
        mode = 2'b10; a = 8'h01; b = 8'h01;
        tick();
        mode = 2'b11; a = 8'hFF; b = 8'hFF;
        tick();
        checks++;
        if (q !== 8'hFF || err !== 8'h01 || err_cnt !== 2'd1) begin
            errors++; $display("FAIL pre_reset: got q=%h err=%h cnt=%0d want ff/01/1", q, err, err_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (q !== 8'hA5 || qn !== 8'h5A || err !== 8'h00 || err_cnt !== 2'd0) begin
            errors++; $display("FAIL async_reset: got q=%h qn=%h err=%h cnt=%0d want a5/5a/00/0", q, qn, err, err_cnt);
        end
        #2;
        tick();
        checks++;
        if (q !== 8'hA5) begin errors++; $display("FAIL edge_in_reset: got %h want a5", q); end
        rst = 1'b0;
        tick();
        checks++;
        if (q !== 8'h5A) begin errors++; $display("FAIL resume: got %h want 5a", q); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_d_t();
        test_sr();
        test_jk();
        test_clear_sat();
        test_async_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ff_bank.md
# ff_bank

Parametrised bank of WIDTH edge-triggered storage bits. Each bit behaves as a D, T, SR or JK flip-flop, chosen at run time by a shared mode input. The bank adds a synchronous enable, a programmable reset value, and detection and counting of forbidden SR input combinations. It is the clocked, multi-channel successor to the single-bit latch set. It serves as the general-purpose state element for the later counter and shift-register blocks.

## Interface
- WIDTH, 8: number of storage bits (channels), must be at least 1.
- RESET_VAL, {WIDTH{1'b0}}: value loaded into q on reset.
- CNT_W, 8: width of the invalid-event counter, must be at least 1.

- clk  in  1  rising-edge clock; the block uses one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- en  in  1  update enable; when low, all state holds.
- mode  in  2  function select shared by all bits: 00 D, 01 T, 10 SR, 11 JK.
- a  in  WIDTH  per-bit primary input (D / T / S / J).
- b  in  WIDTH  per-bit secondary input (R / K); ignored in D and T modes.
- clr_err  in  1  synchronous clear of err and err_cnt.
- q  out  WIDTH  stored state.
- qn  out  WIDTH  always ~q.
- err  out  WIDTH  sticky per-bit flag: an SR invalid input was captured on that bit.
- err_cnt  out  CNT_W  saturating count of cycles with at least one SR invalid bit.

## Operation
- All state updates happen on the rising edge of clk. mode, a, b, en and clr_err are sampled at the same edge; no input is pipelined.
- Each bit i updates independently when en=1:
  - D mode: q[i] <= a[i].
  - T mode: a[i]=1 toggles q[i]; a[i]=0 holds.
  - SR mode:
    - a=1, b=0 sets the bit to 1.
    - a=0, b=1 resets it to 0.
    - a=0, b=0 holds.
    - a=1, b=1 is invalid: q[i] holds and an invalid event is raised on bit i.
  - JK mode: a=1, b=0 sets; a=0, b=1 resets; a=0, b=0 holds; a=1, b=1 toggles.
- When en=0: q, err and err_cnt hold. No invalid events are raised, but clr_err still acts.
- qn is ~q and is derived from the q register, so it has no extra latency and can never equal q.
- Invalid events are raised only when en=1, mode=10 and a[i]&b[i] is set. Call this bit vector inv.
- err update:
  - Normally err <= err | inv.
  - When clr_err=1, err <= inv, so a new event in the clearing cycle is kept.
- err_cnt update:
  - When |inv is set, err_cnt increments by exactly 1 per cycle, however many bits are invalid.
  - err_cnt saturates at 2^CNT_W-1 and never wraps.
  - When clr_err=1, err_cnt <= (|inv ? 1 : 0).
- Mode changes take effect at the edge where the new mode is sampled. Stored q is kept across a mode change.

## Timing
- Reset values: q=RESET_VAL, qn=~RESET_VAL, err=0, err_cnt=0.
- Reset is asynchronous: outputs take reset values immediately on rst rising, with no clock needed, including mid-operation.
- While rst is high, edges are ignored.
- The first update happens at the first rising clk edge after rst falls.
- Latency from input to q / qn / err / err_cnt is 1 clock edge.
- All outputs are registered or an inversion of a register; no combinational path runs from inputs to outputs.

## Test plan
- Reset check (WIDTH=8, RESET_VAL=8'hA5): assert rst with no clock running → q=A5 and qn=5A at once. Release rst, en=0, toggle clk 3 times → q stays A5, err=0, err_cnt=0.
- D then T (en=1): mode=00, a=3C, one edge → q=3C. Then mode=01, a=0F, two edges → q=33, then q=3C.
- SR (start q=00, mode=10): a=F0, b=00 → q=F0. Then a=00, b=30 → q=C0. Then a=03, b=03 → q=C0, err=03, err_cnt=1. Two more such edges → err_cnt=3.
- JK: start q=AA, mode=11, a=b=FF → q=55, then AA. Then a=0F, b=F0 → q=0F. Throughout, err_cnt is unchanged.
- Clear and saturation (CNT_W=2): hold the SR invalid input for 5 edges → err_cnt=3, no wrap. Then clr_err=1 with invalid still present → err=inv, err_cnt=1. Then clr_err=1 with a=b=0 → err=0, err_cnt=0.
- Mid-operation reset: during a JK toggle sequence with err≠0, pulse rst between edges → q=RESET_VAL, err=0 and err_cnt=0 at once. The next edge resumes from RESET_VAL.
